// File: rtl/mc_resolver_pkg.sv
// Shared definitions for the multicast destination resolver: result class
// codes, the IEEE reserved-multicast DA prefix and the one-hot FSM encoding.
package mc_resolver_pkg;

    localparam logic [1:0] CLS_UCAST = 2'd0;
    localparam logic [1:0] CLS_RSVD  = 2'd1;
    localparam logic [1:0] CLS_FLOOD = 2'd2;
    localparam logic [1:0] CLS_DROP  = 2'd3;

    // 01-80-C2-00-00-xx with xx in 00..1F: upper 40 bits fixed, top 3 bits of the last octet zero
    localparam logic [39:0] RSVD_PREFIX  = 40'h0180C20000;
    localparam logic [7:0]  RSVD_MASK_LO = 8'hE0;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        REQ  = 4'b0010,
        REL  = 4'b0100,
        OUT  = 4'b1000
    } state_t;

endpackage

// File: rtl/mc_da_classify.sv
// Combinational destination-MAC classifier: flags IEEE reserved multicast,
// broadcast and any group (multicast) address.
module mc_da_classify
    import mc_resolver_pkg::*;
(
    input  logic [47:0] da,
    output logic        is_rsvd,
    output logic        is_bcast,
    output logic        is_group
);

    assign is_rsvd  = (da[47:8] == RSVD_PREFIX) && ((da[7:0] & RSVD_MASK_LO) == 8'h00);
    assign is_bcast = &da;
    // The group bit is the least significant bit of the first transmitted octet
    assign is_group = da[40];

endmodule

// File: rtl/mc_dest_resolver.sv
// Multicast destination resolver. Classifies each accepted header DA, fetches
// routes for reserved multicast over a 4-phase request/ack/nak handshake to the
// flow table, and emits one masked egress map per header, in order.
// Optional feature: define MC_RESOLVER_TIMEOUT_EN to bound the flow-table wait;
// a silent responder then yields a drop result after TIMEOUT_CYC cycles.
module mc_dest_resolver
    import mc_resolver_pkg::*;
#(
    parameter int          PORT_W      = 4,
    parameter logic [15:0] FLOOD_MAP   = 16'hFFFF,
    parameter int          TIMEOUT_CYC = 64
) (
    input  logic              clk_sys,
    input  logic              rst_sys,
    input  logic              hdr_valid,
    output logic              hdr_ready,
    input  logic [47:0]       hdr_da,
    input  logic [PORT_W-1:0] hdr_src_port,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [1:0]        res_cls,
    output logic [15:0]       res_portmap,
    output logic              ftm_req_valid,
    output logic [15:0]       ftm_req_mac,
    input  logic              ftm_resp_ack,
    input  logic              ftm_resp_nak,
    input  logic [15:0]       ftm_resp_result
);

    // The wait counter is 8 bits wide, so the limit must fit in it
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 256) begin : g_timeout_range
        $error("TIMEOUT_CYC must be in 1..256");
    end

    state_t            state;
    logic [PORT_W-1:0] src_q;
    logic              is_rsvd;
    logic              is_bcast;
    logic              is_group;
    logic              hdr_fire;

`ifdef MC_RESOLVER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] wait_cnt;
`endif

    // Clear the source port's own bit; an index beyond bit 15 shifts out and masks nothing
    function automatic logic [15:0] mask_src(input logic [15:0] map, input logic [PORT_W-1:0] src);
        logic [15:0] src_bit;
        src_bit = 16'h0001 << src;
        return map & ~src_bit;
    endfunction

    mc_da_classify u_classify (
        .da       (hdr_da),
        .is_rsvd  (is_rsvd),
        .is_bcast (is_bcast),
        .is_group (is_group)
    );

    // A lingering ack/nak (e.g. after reset) must clear before a new request can start
    assign hdr_ready = (state == IDLE) && !ftm_resp_ack && !ftm_resp_nak;
    assign hdr_fire  = hdr_valid && hdr_ready;

    // Resolver FSM with registered result and flow-table request outputs
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state         <= IDLE;
            src_q         <= '0;
            res_valid     <= 1'b0;
            res_cls       <= CLS_UCAST;
            res_portmap   <= 16'h0000;
            ftm_req_valid <= 1'b0;
            ftm_req_mac   <= 16'h0000;
`ifdef MC_RESOLVER_TIMEOUT_EN
            wait_cnt      <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (hdr_fire) begin
                        src_q <= hdr_src_port;
                        if (is_rsvd) begin
                            // ftm_req_mac doubles as the DA register for the lookup
                            ftm_req_valid <= 1'b1;
                            ftm_req_mac   <= hdr_da[15:0];
`ifdef MC_RESOLVER_TIMEOUT_EN
                            wait_cnt      <= 8'd0;
`endif
                            state         <= REQ;
                        end else begin
                            res_valid <= 1'b1;
                            if (is_bcast || is_group) begin
                                res_cls     <= CLS_FLOOD;
                                res_portmap <= mask_src(FLOOD_MAP, hdr_src_port);
                            end else begin
                                res_cls     <= CLS_UCAST;
                                res_portmap <= 16'h0000;
                            end
                            state <= OUT;
                        end
                    end
                end
                REQ: begin
                    // ack has priority over a simultaneous nak
                    if (ftm_resp_ack) begin
                        res_cls       <= CLS_RSVD;
                        res_portmap   <= mask_src(ftm_resp_result, src_q);
                        ftm_req_valid <= 1'b0;
                        state         <= REL;
                    end else if (ftm_resp_nak) begin
                        res_cls       <= CLS_FLOOD;
                        res_portmap   <= mask_src(FLOOD_MAP, src_q);
                        ftm_req_valid <= 1'b0;
                        state         <= REL;
                    end
`ifdef MC_RESOLVER_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_LAST) begin
                        res_cls       <= CLS_DROP;
                        res_portmap   <= 16'h0000;
                        ftm_req_valid <= 1'b0;
                        state         <= REL;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                REL: begin
                    if (!ftm_resp_ack && !ftm_resp_nak) begin
                        res_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    res_valid     <= 1'b0;
                    res_cls       <= CLS_UCAST;
                    res_portmap   <= 16'h0000;
                    ftm_req_valid <= 1'b0;
                    ftm_req_mac   <= 16'h0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_dest_resolver.sv
// Self-checking bench for mc_dest_resolver: a scoreboard queue of expected
// {class, map} results, a behavioural flow-table responder and a monitor that
// checks results, request timing and header blocking on the falling edge.
module tb_mc_dest_resolver;
    import mc_resolver_pkg::*;

    logic        clk_sys = 1'b0;
    logic        rst_sys;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [47:0] hdr_da;
    logic [3:0]  hdr_src_port;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_cls;
    logic [15:0] res_portmap;
    logic        ftm_req_valid;
    logic [15:0] ftm_req_mac;
    logic        ftm_resp_ack;
    logic        ftm_resp_nak;
    logic [15:0] ftm_resp_result;

    always #5 clk_sys = ~clk_sys;

    mc_dest_resolver #(
        .PORT_W      (4),
        .FLOOD_MAP   (16'hFFFF),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk_sys         (clk_sys),
        .rst_sys         (rst_sys),
        .hdr_valid       (hdr_valid),
        .hdr_ready       (hdr_ready),
        .hdr_da          (hdr_da),
        .hdr_src_port    (hdr_src_port),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_cls         (res_cls),
        .res_portmap     (res_portmap),
        .ftm_req_valid   (ftm_req_valid),
        .ftm_req_mac     (ftm_req_mac),
        .ftm_resp_ack    (ftm_resp_ack),
        .ftm_resp_nak    (ftm_resp_nak),
        .ftm_resp_result (ftm_resp_result)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [17:0] exp_q[$];
    logic [15:0] exp_mac = 16'h0000;
    int          req_rises = 0;
    logic        prev_req = 1'b0;
    // responder mode: 0 ack, 1 nak, 2 silent
    int          resp_mode = 0;
    logic [15:0] resp_result = 16'h0000;
    int          resp_hold = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] cls, input logic [15:0] map);
        exp_q.push_back({cls, map});
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic [47:0] da, input logic [3:0] src);
        bit took;
        took = 1'b0;
        hdr_da       = da;
        hdr_src_port = src;
        hdr_valid    = 1'b1;
        for (int i = 0; i < 200 && !took; i++) begin
            @(negedge clk_sys);
            took = hdr_ready;
            tick();
        end
        hdr_valid = 1'b0;
        check_eq("hdr_accept", {31'd0, took}, 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || res_valid) && n < 400) begin
            tick();
            n++;
        end
        check_eq("drain_queue", exp_q.size(), 32'd0);
    endtask

    // Result scoreboard, request-rise and stale-response blocking checks
    always @(negedge clk_sys) begin
        if (!rst_sys) begin
            if (ftm_req_valid && !prev_req) begin
                req_rises++;
                check_eq("req_rise_resp_idle", {30'd0, ftm_resp_ack, ftm_resp_nak}, 32'd0);
                check_eq("req_mac", {16'd0, ftm_req_mac}, {16'd0, exp_mac});
            end
            if (ftm_resp_ack || ftm_resp_nak)
                check_eq("hdr_ready_blocked", {31'd0, hdr_ready}, 32'd0);
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_result", {31'd0, res_valid}, 32'd0);
                end else begin
                    check_eq("res_cls", {30'd0, res_cls}, {30'd0, exp_q[0][17:16]});
                    check_eq("res_map", {16'd0, res_portmap}, {16'd0, exp_q[0][15:0]});
                    if (res_ready) void'(exp_q.pop_front());
                end
            end
        end
        prev_req = ftm_req_valid;
    end

    // Flow-table responder: answers one cycle after seeing a request, holds the
    // response until one cycle (plus resp_hold) after the request drops
    initial begin
        ftm_resp_ack    = 1'b0;
        ftm_resp_nak    = 1'b0;
        ftm_resp_result = 16'h0000;
        forever begin
            tick();
            if (ftm_req_valid && !rst_sys && resp_mode != 2) begin
                tick();
                if (resp_mode == 0) begin
                    ftm_resp_ack    = 1'b1;
                    ftm_resp_result = resp_result;
                end else begin
                    ftm_resp_nak = 1'b1;
                end
                for (int i = 0; i < 50 && ftm_req_valid; i++) tick();
                check_eq("req_drop", {31'd0, ftm_req_valid}, 32'd0);
                repeat (1 + resp_hold) tick();
                ftm_resp_ack    = 1'b0;
                ftm_resp_nak    = 1'b0;
                ftm_resp_result = 16'h0000;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int n;
        rst_sys      = 1'b1;
        hdr_valid    = 1'b0;
        hdr_da       = 48'h0;
        hdr_src_port = 4'h0;
        res_ready    = 1'b1;
        repeat (3) tick();

        // Reset state
        check_eq("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check_eq("rst_res_cls", {30'd0, res_cls}, 32'd0);
        check_eq("rst_res_map", {16'd0, res_portmap}, 32'd0);
        check_eq("rst_req_valid", {31'd0, ftm_req_valid}, 32'd0);
        check_eq("rst_req_mac", {16'd0, ftm_req_mac}, 32'd0);
        check_eq("rst_hdr_ready", {31'd0, hdr_ready}, 32'd1);
        rst_sys = 1'b0;
        tick();

        // T1: reserved DA, ack with 000C, src 2 -> map 0008, single request
        resp_mode = 0; resp_hold = 0; resp_result = 16'h000C; exp_mac = 16'h0000;
        r0 = req_rises;
        push_exp(CLS_RSVD, 16'h0008);
        send(48'h0180C2000000, 4'd2);
        wait_drain();
        check_eq("t1_req_count", req_rises - r0, 32'd1);

        // T2: just outside the reserved range -> flood, no request, 1-cycle latency
        r0 = req_rises;
        push_exp(CLS_FLOOD, 16'hFFFE);
        send(48'h0180C2000021, 4'd0);
        check_eq("t2_latency", {31'd0, res_valid}, 32'd1);
        check_eq("t2_no_req", {31'd0, ftm_req_valid}, 32'd0);
        wait_drain();
        check_eq("t2_req_count", req_rises - r0, 32'd0);

        // T3: unicast then broadcast from port 15
        push_exp(CLS_UCAST, 16'h0000);
        send(48'h001122334455, 4'd15);
        push_exp(CLS_FLOOD, 16'h7FFF);
        send(48'hFFFFFFFFFFFF, 4'd15);
        wait_drain();

        // T4: top of reserved range, responder naks -> flood minus port 5
        resp_mode = 1; exp_mac = 16'h001F;
        push_exp(CLS_FLOOD, 16'hFFDF);
        send(48'h0180C200001F, 4'd5);
        wait_drain();

        // T5: two reserved headers, ack held an extra cycle, first result stalled 5 cycles
        resp_mode = 0; resp_hold = 1; res_ready = 1'b0;
        r0 = req_rises;
        resp_result = 16'h00F6; exp_mac = 16'h0003;
        push_exp(CLS_RSVD, 16'h00F4);
        send(48'h0180C2000003, 4'd1);
        n = 0;
        while (!res_valid && n < 100) begin tick(); n++; end
        check_eq("t5_res_valid", {31'd0, res_valid}, 32'd1);
        repeat (5) tick();
        check_eq("t5_held", {31'd0, res_valid}, 32'd1);
        res_ready = 1'b1;
        resp_result = 16'h0013; exp_mac = 16'h0010;
        push_exp(CLS_RSVD, 16'h0003);
        send(48'h0180C2000010, 4'd4);
        wait_drain();
        check_eq("t5_req_count", req_rises - r0, 32'd2);
        resp_hold = 0;

`ifdef MC_RESOLVER_TIMEOUT_EN
        // T6: silent responder -> drop after the wait limit
        resp_mode = 2; exp_mac = 16'h0002;
        push_exp(CLS_DROP, 16'h0000);
        send(48'h0180C2000002, 4'd3);
        n = 0;
        while (!res_valid && n < 200) begin tick(); n++; end
        check_eq("t6_timeout_latency", n, 32'd65);
        wait_drain();
`endif

        // Reset during an outstanding request: request drops, no result appears
        resp_mode = 2; exp_mac = 16'h0004;
        send(48'h0180C2000004, 4'd6);
        repeat (3) tick();
        check_eq("mid_req_active", {31'd0, ftm_req_valid}, 32'd1);
        rst_sys = 1'b1;
        tick();
        check_eq("mid_rst_req_drop", {31'd0, ftm_req_valid}, 32'd0);
        check_eq("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
        rst_sys = 1'b0;
        repeat (10) tick();
        check_eq("post_rst_no_result", {31'd0, res_valid}, 32'd0);

        // Recovery after reset
        resp_mode = 0; resp_result = 16'hFFFF; exp_mac = 16'h000E;
        push_exp(CLS_RSVD, 16'hFF7F);
        send(48'h0180C200000E, 4'd7);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
